// File: rtl/lynx_ram_pkg.sv
// lynx_ram_pkg: shared types and defaults for the Lynx SDRAM port arbiter.
package lynx_ram_pkg;
    localparam int RAM_AW = 23;
    localparam int TIMEOUT_DEF = 255;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
    typedef struct packed {
        logic [RAM_AW-1:0] addr;
        logic [7:0]        data;
    } dl_req_t;
endpackage

// File: rtl/lynx_dl_fifo.sv
// lynx_dl_fifo: small synchronous FIFO of download requests; push and pop may coincide when full.
module lynx_dl_fifo
    import lynx_ram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    push,
    input  logic    pop,
    input  dl_req_t din,
    output dl_req_t dout,
    output logic    full,
    output logic    empty
);
    localparam int PW = $clog2(DEPTH);
    dl_req_t mem [DEPTH];
    logic [PW:0] wp, rp;
    logic do_push, do_pop;
    // pointers carry an extra wrap bit so full and empty are distinguishable
    assign empty   = wp == rp;
    assign full    = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rp[PW-1:0]];
    always_ff @(posedge clock) begin
        if (do_push) mem[wp[PW-1:0]] <= din;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
        end
    end
endmodule

// File: rtl/lynx_ram_arbiter.sv
// lynx_ram_arbiter: shares one 8-bit SDRAM port between the download stream and the CPU,
// one access outstanding at a time.
module lynx_ram_arbiter
    import lynx_ram_pkg::*;
#(
    parameter int             AW         = RAM_AW,
    parameter int             FIFO_DEPTH = 4,
    parameter logic [AW-1:0]  DL_BASE    = '0,
    parameter int             TIMEOUT    = TIMEOUT_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          dl_active,
    input  logic          dl_wr,
    input  logic [24:0]   dl_addr,
    input  logic [7:0]    dl_data,
    output logic          dl_busy,
    output logic          dl_ovf,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_ack,
    output logic [AW-1:0] sdram_addr,
    output logic [7:0]    sdram_din,
    output logic          sdram_rd,
    output logic          sdram_we,
    input  logic [7:0]    sdram_dout,
    input  logic          sdram_ready,
    output logic          tmo_err
);
    state_e state, nxt;
    dl_req_t fifo_in, fifo_out;
    logic full, empty, cpu_req, grant_fifo, grant_cpu;
    logic cur_we, cur_cpu, prefer_cpu, dl_q;
    logic [AW-1:0] cur_addr;
    logic [7:0] cur_din, dout_q, cnt;
    logic unused_addr_bits;
    assign unused_addr_bits = ^dl_addr[24:AW];
    assign fifo_in = '{addr: RAM_AW'(dl_addr[AW-1:0] + DL_BASE), data: dl_data};
    assign cpu_req = cpu_rd | cpu_wr;
    // an active download always beats the CPU; otherwise alternate
    assign grant_fifo = state == IDLE && !empty && (dl_active || !prefer_cpu || !cpu_req);
    assign grant_cpu  = state == IDLE && cpu_req && !grant_fifo;

    lynx_dl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock(clock),
        .reset(reset),
        .push (dl_wr),
        .pop  (grant_fifo),
        .din  (fifo_in),
        .dout (fifo_out),
        .full (full),
        .empty(empty)
    );

    always_comb begin
        nxt        = state;
        sdram_rd   = state == ISSUE && !cur_we;
        sdram_we   = state == ISSUE && cur_we;
        cpu_ack    = state == DONE && cur_cpu;
        sdram_addr = cur_addr;
        sdram_din  = cur_din;
        cpu_dout   = dout_q;
        dl_busy    = dl_active || !empty || (state != IDLE && !cur_cpu);
        unique case (state)
            IDLE:    nxt = (grant_fifo || grant_cpu) ? ISSUE : IDLE;
            ISSUE:   nxt = WAIT;
            WAIT:    nxt = sdram_ready ? DONE : (cnt == 8'(TIMEOUT - 1)) ? IDLE : WAIT;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cur_addr   <= '0;
            cur_din    <= '0;
            cur_we     <= 1'b0;
            cur_cpu    <= 1'b0;
            prefer_cpu <= 1'b1;
            dl_q       <= 1'b0;
            dout_q     <= '0;
            cnt        <= '0;
            dl_ovf     <= 1'b0;
            tmo_err    <= 1'b0;
        end else begin
            state <= nxt;
            dl_q  <= dl_active;
            cnt   <= (state == WAIT) ? cnt + 8'd1 : 8'd0;
            if (grant_fifo || grant_cpu) begin
                cur_cpu    <= grant_cpu;
                cur_we     <= grant_fifo || cpu_wr;
                cur_addr   <= grant_fifo ? AW'(fifo_out.addr) : cpu_addr;
                cur_din    <= grant_fifo ? fifo_out.data : cpu_din;
                prefer_cpu <= grant_fifo;
            end
            if (state == WAIT && sdram_ready && cur_cpu) dout_q <= sdram_dout;
            if (state == WAIT && !sdram_ready && cnt == 8'(TIMEOUT - 1)) tmo_err <= 1'b1;
            if (dl_active && !dl_q) dl_ovf <= 1'b0;
            if (dl_wr && full && !grant_fifo) dl_ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lynx_ram_arbiter.sv
// tb_lynx_ram_arbiter: directed checks of the SDRAM arbiter against a simple SDRAM responder.
module tb_lynx_ram_arbiter;
    logic clock = 1'b0, reset;
    logic dl_active, dl_wr, dl_busy, dl_ovf;
    logic [24:0] dl_addr;
    logic [7:0] dl_data, cpu_din, cpu_dout, sdram_din, sdram_dout;
    logic cpu_rd, cpu_wr, cpu_ack, sdram_rd, sdram_we, sdram_ready, tmo_err;
    logic [22:0] cpu_addr, sdram_addr, exp_addr;
    int checks = 0, errors = 0;
    int lat = 2, n, acks;
    logic no_ready = 1'b0;
    logic [7:0] rdata = 8'h00;
    logic [22:0] log_addr[$];
    logic log_we[$];
    logic [7:0] log_din[$];

    always #5 clock = ~clock;

    lynx_ram_arbiter #(.DL_BASE(23'h7FFFFE)) dut (
        .clock(clock), .reset(reset),
        .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .dl_busy(dl_busy), .dl_ovf(dl_ovf),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .sdram_addr(sdram_addr), .sdram_din(sdram_din), .sdram_rd(sdram_rd), .sdram_we(sdram_we),
        .sdram_dout(sdram_dout), .sdram_ready(sdram_ready), .tmo_err(tmo_err)
    );

    // SDRAM responder: logs each command, answers `lat` cycles later
    initial begin
        sdram_ready = 1'b0;
        sdram_dout  = 8'h00;
        forever begin
            @(negedge clock);
            if (sdram_rd || sdram_we) begin
                log_addr.push_back(sdram_addr);
                log_we.push_back(sdram_we);
                log_din.push_back(sdram_din);
                if (!no_ready) begin
                    repeat (lat) @(posedge clock);
                    #1 sdram_dout = rdata;
                    sdram_ready = 1'b1;
                    @(posedge clock);
                    #1 sdram_ready = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_cmd(output int cyc);
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (!(sdram_rd || sdram_we) && cyc < 50);
    endtask

    task automatic wait_ack(output int cyc);
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (!cpu_ack && cyc < 50);
    endtask

    task automatic wait_idle_dl;
        n = 0;
        while (dl_busy && n < 300) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic clear_log;
        log_addr.delete();
        log_we.delete();
        log_din.delete();
    endtask

    initial begin
        reset = 1'b1;
        {dl_active, dl_wr, cpu_rd, cpu_wr} = '0;
        dl_addr = '0; dl_data = '0; cpu_addr = '0; cpu_din = '0;
        repeat (2) @(negedge clock);
        chk("rst_ack", cpu_ack, 0);
        chk("rst_cmd", {sdram_rd, sdram_we}, 0);
        chk("rst_flags", {dl_busy, dl_ovf, tmo_err}, 0);
        chk("rst_addr", sdram_addr, 0);
        chk("rst_dout", cpu_dout, 0);
        @(posedge clock); #1 reset = 1'b0;
        tick;

        // CPU read latency and data
        lat = 5; rdata = 8'hA5; cpu_addr = 23'h1234; cpu_rd = 1'b1;
        @(negedge clock);
        chk("rd_not_at_n", sdram_rd, 0);
        @(negedge clock);
        chk("rd_at_n1", sdram_rd, 1);
        chk("rd_addr", sdram_addr, 23'h1234);
        wait_ack(n);
        cpu_rd = 1'b0;
        chk("rd_ack_lat", n, 6);
        chk("rd_dout", cpu_dout, 8'hA5);
        @(negedge clock);
        chk("rd_ack_pulse", cpu_ack, 0);

        // rd and wr together act as a write
        tick; clear_log();
        lat = 2; cpu_addr = 23'h42; cpu_din = 8'h5A; cpu_rd = 1'b1; cpu_wr = 1'b1;
        wait_ack(n);
        {cpu_rd, cpu_wr} = '0;
        chk("rw_ack", cpu_ack, 1);
        chk("rw_cnt", log_we.size(), 1);
        if (log_we.size() == 1) chk("rw_is_we", {log_we[0], log_din[0], log_addr[0]}, {1'b1, 8'h5A, 23'h42});

        // async reset in the middle of WAIT
        tick; no_ready = 1'b1; cpu_addr = 23'h55; cpu_rd = 1'b1;
        wait_cmd(n);
        cpu_rd = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_outs", {sdram_rd, sdram_we, cpu_ack, dl_busy, dl_ovf, tmo_err}, 0);
        chk("mid_rst_addr", sdram_addr, 0);
        @(posedge clock); #1 reset = 1'b0;
        no_ready = 1'b0; lat = 2; cpu_addr = 23'h77; cpu_rd = 1'b1;
        wait_cmd(n);
        chk("post_rst_lat", n, 2);
        chk("post_rst_rd", {sdram_rd, sdram_addr}, {1'b1, 23'h77});
        wait_ack(n);
        cpu_rd = 1'b0;
        chk("post_rst_ack", cpu_ack, 1);

        // download burst overflows the FIFO
        tick; clear_log(); lat = 4; dl_active = 1'b1;
        tick;
        for (int i = 0; i < 6; i++) begin
            dl_wr = 1'b1; dl_addr = 25'(i); dl_data = 8'(8'h10 + i);
            tick;
        end
        dl_wr = 1'b0;
        @(negedge clock);
        chk("dl_ovf_set", dl_ovf, 1);
        n = 0;
        while (log_we.size() < 5 && n < 200) begin
            @(negedge clock);
            n++;
        end
        dl_active = 1'b0;
        wait_idle_dl();
        chk("dl_drained", dl_busy, 0);
        chk("dl_count", log_we.size(), 5);
        for (int i = 0; i < 5 && i < log_we.size(); i++) begin
            exp_addr = 23'h7FFFFE + 23'(i);
            chk($sformatf("dl_entry%0d", i), {log_we[i], log_din[i], log_addr[i]},
                {1'b1, 8'(8'h10 + i), exp_addr});
        end
        chk("dl_ovf_held", dl_ovf, 1);

        // dl_active re-rise clears overflow; address wraps modulo 2^23
        tick; clear_log(); dl_active = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("dl_ovf_clr", dl_ovf, 0);
        tick;
        dl_wr = 1'b1; dl_addr = 25'h1000003; dl_data = 8'h3C;
        tick;
        dl_wr = 1'b0;
        wait_cmd(n);
        chk("wrap_cmd", {sdram_we, sdram_rd, sdram_din, sdram_addr}, {1'b1, 1'b0, 8'h3C, 23'h000001});
        dl_active = 1'b0;
        wait_idle_dl();
        chk("wrap_idle", dl_busy, 0);

        // round-robin with dl_active low
        tick; clear_log(); lat = 2; cpu_addr = 23'h300; cpu_rd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dl_wr = 1'b1; dl_addr = 25'(25'h10 + i); dl_data = 8'(i);
            tick;
        end
        dl_wr = 1'b0;
        n = 0;
        while (log_we.size() < 6 && n < 300) begin
            @(negedge clock);
            n++;
        end
        cpu_rd = 1'b0;
        wait_idle_dl();
        chk("rr_count", log_we.size(), 6);
        for (int i = 0; i < 6 && i < log_we.size(); i++)
            chk($sformatf("rr_order%0d", i), {log_we[i], log_addr[i]},
                (i % 2 == 1) ? {1'b1, 23'(23'h00000E + i / 2)} : {1'b0, 23'h300});

        // no ready: timeout after 255 WAIT cycles, no ack
        tick; no_ready = 1'b1; cpu_addr = 23'h99; cpu_rd = 1'b1;
        wait_cmd(n);
        cpu_rd = 1'b0;
        n = 0; acks = 0;
        while (!tmo_err && n < 400) begin
            @(negedge clock);
            n++;
            if (cpu_ack) acks++;
        end
        chk("tmo_lat", n, 256);
        chk("tmo_no_ack", acks, 0);
        no_ready = 1'b0; tick; cpu_addr = 23'hAA; cpu_rd = 1'b1;
        wait_ack(n);
        cpu_rd = 1'b0;
        chk("tmo_recover_ack", cpu_ack, 1);
        chk("tmo_sticky", tmo_err, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
